// File: rtl/rs_age_sel.sv
// Reservation station: DEPTH entries woken from NUM_CDB broadcast channels; issues the
// oldest ready entry through a registered valid/ready stage (latency: ready entry -> iss one edge).
module rs_age_sel #(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 2,
  parameter int ROB_W   = 4,
  parameter int XLEN    = 32,
  parameter int OP_W    = 5
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       rdy_in,
  input  logic                       clear,
  input  logic                       dec_valid,
  input  logic [OP_W-1:0]            dec_op,
  input  logic [XLEN-1:0]            dec_vj,
  input  logic [XLEN-1:0]            dec_vk,
  input  logic                       dec_dj,
  input  logic                       dec_dk,
  input  logic [ROB_W-1:0]           dec_qj,
  input  logic [ROB_W-1:0]           dec_qk,
  input  logic [ROB_W-1:0]           dec_rob_id,
  input  logic [XLEN-1:0]            dec_tja,
  input  logic [XLEN-1:0]            dec_fja,
  output logic                       rs_full,
  output logic [$clog2(DEPTH):0]     rs_count,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0]   cdb_rob_id,
  input  logic [NUM_CDB*XLEN-1:0]    cdb_value,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [OP_W-1:0]            iss_op,
  output logic [XLEN-1:0]            iss_lhs,
  output logic [XLEN-1:0]            iss_rhs,
  output logic [ROB_W-1:0]           iss_rob_id,
  output logic [XLEN-1:0]            iss_tja,
  output logic [XLEN-1:0]            iss_fja
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
    logic             dj;
    logic             dk;
    logic [ROB_W-1:0] qj;
    logic [ROB_W-1:0] qk;
    logic [ROB_W-1:0] rob_id;
    logic [XLEN-1:0]  tja;
    logic [XLEN-1:0]  fja;
  } ent_t;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  lhs;
    logic [XLEN-1:0]  rhs;
    logic [ROB_W-1:0] rob_id;
    logic [XLEN-1:0]  tja;
    logic [XLEN-1:0]  fja;
  } iss_t;

  ent_t             ent_q   [DEPTH];
  ent_t             ent_d   [DEPTH];
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];
  iss_t             iss_q;
  iss_t             iss_d;

  logic [DEPTH-1:0] rdy_vec;
  logic [DEPTH-1:0] sel_vec;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] free_idx;
  logic             any_rdy;
  logic             any_free;
  logic             do_load;
  logic             do_disp;
  logic [CNT_W-1:0] cnt;
  logic             byp_j_hit;
  logic             byp_k_hit;
  logic [XLEN-1:0]  byp_j_val;
  logic [XLEN-1:0]  byp_k_val;

  // Status, oldest-ready select and free-slot pick, all from registered state.
  always_comb begin
    cnt      = '0;
    rdy_vec  = '0;
    sel_vec  = '0;
    sel_idx  = '0;
    free_idx = '0;
    any_free = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy_vec[i] = ent_q[i].valid && !ent_q[i].dj && !ent_q[i].dk;
      cnt        = cnt + CNT_W'(ent_q[i].valid);
    end
    for (int i = 0; i < DEPTH; i++) begin
      sel_vec[i] = rdy_vec[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (rdy_vec[j] && older_q[j][i]) sel_vec[i] = 1'b0;
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (sel_vec[i]) sel_idx = IDX_W'(i);
      if (!ent_q[i].valid) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
    any_rdy = |rdy_vec;
  end

  // Dispatch bypass; descending scan so the lowest matching channel wins.
  always_comb begin
    byp_j_hit = 1'b0;
    byp_k_hit = 1'b0;
    byp_j_val = '0;
    byp_k_val = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (dec_dj && cdb_valid[c] && cdb_rob_id[c*ROB_W +: ROB_W] == dec_qj) begin
        byp_j_hit = 1'b1;
        byp_j_val = cdb_value[c*XLEN +: XLEN];
      end
      if (dec_dk && cdb_valid[c] && cdb_rob_id[c*ROB_W +: ROB_W] == dec_qk) begin
        byp_k_hit = 1'b1;
        byp_k_val = cdb_value[c*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    ent_d   = ent_q;
    older_d = older_q;
    iss_d   = iss_q;
    do_load = (!iss_q.valid || iss_ready) && any_rdy;
    do_disp = dec_valid && any_free;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].valid = 1'b0;
        older_d[i]     = '0;
      end
      iss_d.valid = 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
          if (ent_q[i].valid && ent_q[i].dj && cdb_valid[c] &&
              cdb_rob_id[c*ROB_W +: ROB_W] == ent_q[i].qj) begin
            ent_d[i].dj = 1'b0;
            ent_d[i].vj = cdb_value[c*XLEN +: XLEN];
          end
          if (ent_q[i].valid && ent_q[i].dk && cdb_valid[c] &&
              cdb_rob_id[c*ROB_W +: ROB_W] == ent_q[i].qk) begin
            ent_d[i].dk = 1'b0;
            ent_d[i].vk = cdb_value[c*XLEN +: XLEN];
          end
        end
      end
      if (do_load) begin
        iss_d.valid          = 1'b1;
        iss_d.op             = ent_q[sel_idx].op;
        iss_d.lhs            = ent_q[sel_idx].vj;
        iss_d.rhs            = ent_q[sel_idx].vk;
        iss_d.rob_id         = ent_q[sel_idx].rob_id;
        iss_d.tja            = ent_q[sel_idx].tja;
        iss_d.fja            = ent_q[sel_idx].fja;
        ent_d[sel_idx].valid = 1'b0;
      end else if (iss_ready) begin
        iss_d.valid = 1'b0;
      end
      // The free slot is invalid, so it can never be the selected slot.
      if (do_disp) begin
        ent_d[free_idx].valid  = 1'b1;
        ent_d[free_idx].op     = dec_op;
        ent_d[free_idx].vj     = byp_j_hit ? byp_j_val : dec_vj;
        ent_d[free_idx].vk     = byp_k_hit ? byp_k_val : dec_vk;
        ent_d[free_idx].dj     = dec_dj && !byp_j_hit;
        ent_d[free_idx].dk     = dec_dk && !byp_k_hit;
        ent_d[free_idx].qj     = dec_qj;
        ent_d[free_idx].qk     = dec_qk;
        ent_d[free_idx].rob_id = dec_rob_id;
        ent_d[free_idx].tja    = dec_tja;
        ent_d[free_idx].fja    = dec_fja;
        older_d[free_idx]      = '0;
        for (int x = 0; x < DEPTH; x++) begin
          older_d[x][free_idx] = ent_q[x].valid;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i]   <= '0;
        older_q[i] <= '0;
      end
      iss_q <= '0;
    end else if (rdy_in) begin
      ent_q   <= ent_d;
      older_q <= older_d;
      iss_q   <= iss_d;
    end
  end

  assign rs_full    = !any_free;
  assign rs_count   = cnt;
  assign iss_valid  = iss_q.valid;
  assign iss_op     = iss_q.op;
  assign iss_lhs    = iss_q.lhs;
  assign iss_rhs    = iss_q.rhs;
  assign iss_rob_id = iss_q.rob_id;
  assign iss_tja    = iss_q.tja;
  assign iss_fja    = iss_q.fja;

endmodule

// File: tb/tb_rs_age_sel.sv
// Bench for rs_age_sel: vector table for single-op dispatch/bypass plus hand sequences for
// wakeup order, age ordering, backpressure/full, freeze, clear and reset; issues scored from a queue.
module tb_rs_age_sel;
  localparam int DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        clear;
  logic        dec_valid;
  logic [4:0]  dec_op;
  logic [31:0] dec_vj, dec_vk, dec_tja, dec_fja;
  logic        dec_dj, dec_dk;
  logic [3:0]  dec_qj, dec_qk, dec_rob_id;
  logic        rs_full;
  logic [3:0]  rs_count;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_id;
  logic [63:0] cdb_value;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_op;
  logic [31:0] iss_lhs, iss_rhs, iss_tja, iss_fja;
  logic [3:0]  iss_rob_id;

  rs_age_sel #(.DEPTH(DEPTH), .NUM_CDB(2), .ROB_W(4), .XLEN(32), .OP_W(5)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear(clear),
    .dec_valid(dec_valid), .dec_op(dec_op), .dec_vj(dec_vj), .dec_vk(dec_vk),
    .dec_dj(dec_dj), .dec_dk(dec_dk), .dec_qj(dec_qj), .dec_qk(dec_qk),
    .dec_rob_id(dec_rob_id), .dec_tja(dec_tja), .dec_fja(dec_fja),
    .rs_full(rs_full), .rs_count(rs_count),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_lhs(iss_lhs), .iss_rhs(iss_rhs), .iss_rob_id(iss_rob_id),
    .iss_tja(iss_tja), .iss_fja(iss_fja)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0]  rob;
    logic [4:0]  op;
    logic [31:0] lhs;
    logic [31:0] rhs;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] vj, vk;
    logic        dj, dk;
    logic [3:0]  qj, qk, rob;
    logic [1:0]  cv;
    logic [3:0]  t0;
    logic [31:0] c0;
    logic [3:0]  t1;
    logic [31:0] c1;
    logic [31:0] elhs, erhs;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   proto_errs = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [3:0] rob, input logic [4:0] op, input logic [31:0] lhs, rhs);
    exp_t e;
    e.rob = rob; e.op = op; e.lhs = lhs; e.rhs = rhs;
    sb.push_back(e);
  endtask

  task automatic disp(input logic [4:0] op, input logic [31:0] vj, vk, input logic dj, dk,
                      input logic [3:0] qj, qk, rob);
    dec_valid = 1'b1; dec_op = op; dec_vj = vj; dec_vk = vk;
    dec_dj = dj; dec_dk = dk; dec_qj = qj; dec_qk = qk; dec_rob_id = rob;
    dec_tja = 32'hA000_0000 | 32'(rob);
    dec_fja = 32'hB000_0000 | 32'(rob);
  endtask

  task automatic cdb(input logic [1:0] v, input logic [3:0] t0, input logic [31:0] c0,
                     input logic [3:0] t1, input logic [31:0] c1);
    cdb_valid = v; cdb_rob_id = {t1, t0}; cdb_value = {c1, c0};
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((sb.size() != 0 || iss_valid) && n < 200) begin
      tick();
      n++;
    end
    chk(nm, (sb.size() == 0 && !iss_valid), 1);
  endtask

  // Scoreboard: a handshake completes at the next edge when sampled here.
  always @(negedge clk_in) begin
    if (rst_n_in && rdy_in && !clear && iss_valid && iss_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue actual rob=%0d required none", iss_rob_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("iss_rob_id", iss_rob_id, e.rob);
        chk("iss_lhs", iss_lhs, e.lhs);
        chk("iss_rhs", iss_rhs, e.rhs);
        chk("iss_op_tgt", {iss_op, iss_tja, iss_fja},
            {e.op, 32'hA000_0000 | 32'(e.rob), 32'hB000_0000 | 32'(e.rob)});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{5'h00, 32'd5, 32'd7, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 32'd5, 32'd7};
    vecs[1] = '{5'h10, 32'd1, 32'd2, 1'b1, 1'b0, 4'd2, 4'd0, 4'd4, 2'b01, 4'd2, 32'hAB, 4'd0, 32'h0, 32'hAB, 32'd2};
    vecs[2] = '{5'h0D, 32'h21, 32'h22, 1'b0, 1'b1, 4'd0, 4'd6, 4'd5, 2'b11, 4'd7, 32'h77, 4'd6, 32'h66, 32'h21, 32'h66};
    vecs[3] = '{5'h03, 32'h0, 32'h0, 1'b1, 1'b1, 4'd4, 4'd4, 4'd6, 2'b11, 4'd4, 32'h44, 4'd4, 32'h55, 32'h44, 32'h44};
    vecs[4] = '{5'h08, 32'h99, 32'h0, 1'b0, 1'b1, 4'd5, 4'd1, 4'd7, 2'b11, 4'd5, 32'h12, 4'd1, 32'h01, 32'h99, 32'h01};
    vecs[5] = '{5'h1F, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd15, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 32'hFFFF_FFFF, 32'h0};

    rst_n_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; iss_ready = 1'b1;
    disp(5'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    dec_valid = 1'b0;
    cdb(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    #12;
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_rs_count", rs_count, 0);
    chk("rst_rs_full", rs_full, 0);
    chk("rst_iss_data", {iss_op, iss_lhs, iss_rhs, iss_rob_id}, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tick();

    // Single ops: plain, bypass on j/k, lowest-channel wins, dep flag low ignores CDB.
    for (int i = 0; i < 6; i++) begin
      disp(vecs[i].op, vecs[i].vj, vecs[i].vk, vecs[i].dj, vecs[i].dk, vecs[i].qj, vecs[i].qk, vecs[i].rob);
      cdb(vecs[i].cv, vecs[i].t0, vecs[i].c0, vecs[i].t1, vecs[i].c1);
      push(vecs[i].rob, vecs[i].op, vecs[i].elhs, vecs[i].erhs);
      tick();
      dec_valid = 1'b0;
      cdb(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
      chk("lat_not_yet", iss_valid, 0);
      tick();
      chk("lat_valid", iss_valid, 1);
      tick();
      chk("lat_drop", iss_valid, 0);
    end
    chk("vec_sb_empty", sb.size(), 0);

    // Waiting entry is overtaken by a younger ready one, then woken by channel 1.
    disp(5'h0, 32'h0, 32'h3, 1'b1, 1'b0, 4'd9, 4'd0, 4'd1);
    tick();
    disp(5'h0, 32'h2, 32'h2, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2);
    push(4'd2, 5'h0, 32'h2, 32'h2);
    tick();
    dec_valid = 1'b0;
    cdb(2'b11, 4'd3, 32'h33, 4'd9, 32'h11);
    push(4'd1, 5'h0, 32'h11, 32'h3);
    tick();
    cdb(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    drain("wake_drain");

    // Age: fillers in slots 0..2 are released high-slot first, refilled with robs 4,5,6.
    disp(5'h1, 32'h0, 32'h0, 1'b1, 1'b0, 4'd10, 4'd0, 4'd7); tick();
    disp(5'h1, 32'h0, 32'h0, 1'b1, 1'b0, 4'd11, 4'd0, 4'd8); tick();
    disp(5'h1, 32'h0, 32'h0, 1'b1, 1'b0, 4'd12, 4'd0, 4'd9); tick();
    dec_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [3:0] ftag;
      logic [3:0] frob;
      logic [3:0] nrob;
      ftag = 4'(12 - k);
      frob = 4'(9 - k);
      nrob = 4'(4 + k);
      cdb(2'b01, ftag, 32'(ftag), 4'd0, 32'h0);
      push(frob, 5'h1, 32'(ftag), 32'h0);
      tick();
      cdb(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
      tick(); tick();
      disp(5'h2, 32'h0, 32'h0, 1'b1, 1'b0, 4'd13, 4'd0, nrob);
      tick();
      dec_valid = 1'b0;
    end
    chk("age_count", rs_count, 3);
    cdb(2'b10, 4'd0, 32'h0, 4'd13, 32'hD);
    push(4'd4, 5'h2, 32'hD, 32'h0);
    push(4'd5, 5'h2, 32'hD, 32'h0);
    push(4'd6, 5'h2, 32'hD, 32'h0);
    tick();
    cdb(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    drain("age_drain");

    // Backpressure: DEPTH+2 ready ops with iss_ready low; the last one finds rs_full.
    iss_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      disp(5'(i), 32'h100 + 32'(i), 32'h200 + 32'(i), 1'b0, 1'b0, 4'd0, 4'd0, 4'(i));
      if (rs_full) begin
        proto_errs++;
        $display("protocol error: dispatch of rob %0d while rs_full, dropped", i);
      end else begin
        push(4'(i), 5'(i), 32'h100 + 32'(i), 32'h200 + 32'(i));
      end
      tick();
    end
    dec_valid = 1'b0;
    chk("drop_flagged", proto_errs, 1);
    chk("full_flag", rs_full, 1);
    chk("full_count", rs_count, DEPTH);
    chk("full_iss_valid", iss_valid, 1);
    tick(); tick(); tick();
    chk("stall_rob", iss_rob_id, 0);
    chk("stall_lhs", {iss_lhs, iss_rhs}, {32'h100, 32'h200});
    iss_ready = 1'b1;
    tick(); tick(); tick();
    chk("drain3_count", rs_count, DEPTH - 3);
    rdy_in = 1'b0;
    disp(5'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd14);
    cdb(2'b11, 4'd1, 32'h1, 4'd2, 32'h2);
    for (int i = 0; i < 5; i++) tick();
    chk("freeze_count", rs_count, DEPTH - 3);
    chk("freeze_iss", {iss_valid, iss_rob_id}, {1'b1, 4'd3});
    dec_valid = 1'b0;
    cdb(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    rdy_in = 1'b1;
    drain("full_drain");

    // clear with an op in the issue stage and three waiting.
    iss_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(5'h0, 32'(i), 32'(i), 1'b0, 1'b0, 4'd0, 4'd0, 4'(10 + i));
      tick();
    end
    dec_valid = 1'b0;
    chk("pre_clear_count", rs_count, 3);
    chk("pre_clear_valid", iss_valid, 1);
    clear = 1'b1; iss_ready = 1'b1;
    disp(5'h0, 32'h5, 32'h5, 1'b0, 1'b0, 4'd0, 4'd0, 4'd15);
    tick();
    clear = 1'b0; dec_valid = 1'b0;
    sb.delete();
    chk("clear_valid", iss_valid, 0);
    chk("clear_count", rs_count, 0);
    tick(); tick();
    chk("clear_no_issue", {iss_valid, rs_count}, 0);

    // Asynchronous reset mid-operation.
    iss_ready = 1'b0;
    disp(5'h0, 32'h7, 32'h8, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1); tick();
    disp(5'h0, 32'h9, 32'hA, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2); tick();
    dec_valid = 1'b0;
    chk("pre_rst_valid", iss_valid, 1);
    #3;
    rst_n_in = 1'b0;
    #1;
    chk("mid_rst_valid", iss_valid, 0);
    chk("mid_rst_count", rs_count, 0);
    chk("mid_rst_data", {iss_lhs, iss_rob_id}, 0);
    sb.delete();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    iss_ready = 1'b1;
    tick(); tick();
    chk("post_rst_idle", {iss_valid, rs_count}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
